// File: rtl/mux_channel_sequencer.sv
// Round-robin sequencer in front of a 4:1 MUX: grants one requester, holds Sel/enable
// for SETTLE cycles, captures the MUX output and hands it out on a valid/ready port.
module mux_channel_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] mux_y,
  output logic [1:0]       Sel,
  output logic             enable,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       ack,
  output logic             busy
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("mux_channel_sequencer: SETTLE must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_e;

  state_e           state_q;
  logic [1:0]       rr_ptr_q;
  logic [3:0]       cnt_q;
  logic [1:0]       sel_q;
  logic             enable_q;
  logic [WIDTH-1:0] out_data_q;
  logic [1:0]       out_chan_q;
  logic             out_valid_q;
  logic [3:0]       ack_q;
  logic             busy_q;
  logic [1:0]       grant_d;

  // First set request bit at or after the round-robin pointer, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign grant_d = rr_pick(req, rr_ptr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, including the output word, is cleared so a reset mid-transaction
    // drops it cleanly; non-blocking assignments keep all state updates edge-consistent.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      enable_q    <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            sel_q    <= grant_d;
            enable_q <= 1'b1;
            cnt_q    <= 4'(SETTLE - 1);
            busy_q   <= 1'b1;
            state_q  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            out_data_q  <= mux_y;
            out_chan_q  <= sel_q;
            out_valid_q <= 1'b1;
            enable_q    <= 1'b0;
            state_q     <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            ack_q       <= 4'b0001 << out_chan_q;
            rr_ptr_q    <= out_chan_q + 2'd1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Sel       = sel_q;
  assign enable    = enable_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
  assign ack       = ack_q;
  assign busy      = busy_q;

endmodule
